// File: rtl/pos_scan.sv
// Row-multiplexed 8x8 LED scanner for the RAM position table, with per-frame snapshot.
// Optional POS_SCAN_BLANK_EN: blank row/col on the last cycle of each row slot.
module pos_scan #(
    parameter int unsigned DIV = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] q2,
    output logic [7:0]  row,
    output logic [7:0]  col,
    output logic        frame_start
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [2:0]    ridx;
    logic [47:0]   snap;

    logic          frame_edge_c;
    logic          slot_end_c;
    logic [47:0]   table_c;
    logic [7:0]    row_c;
    logic [7:0]    col_c;

    // One dot per entry whose y matches the row; duplicates merge naturally via OR.
    function automatic logic [7:0] decode(input logic [47:0] s, input logic [2:0] r);
        logic [7:0] d;
        logic [2:0] x;
        logic [2:0] y;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            x = s[47 - 6*i -: 3];
            y = s[44 - 6*i -: 3];
            if (y == r) begin
                d = d | (8'd1 << x);
            end
        end
        return d;
    endfunction

    always_comb begin
        frame_edge_c = (cnt == '0) && (ridx == '0);
        slot_end_c   = (cnt == CW'(DIV - 1));
        // On the snapshot edge the live table is used so row 0 shows it at once.
        table_c      = frame_edge_c ? q2 : snap;
        row_c        = 8'd1 << ridx;
        col_c        = decode(table_c, ridx);
`ifdef POS_SCAN_BLANK_EN
        if (slot_end_c) begin
            row_c = 8'h00;
            col_c = 8'h00;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            ridx        <= '0;
            snap        <= '0;
            row         <= 8'h00;
            col         <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            if (slot_end_c) begin
                cnt  <= '0;
                ridx <= ridx + 3'd1;
            end else begin
                cnt  <= cnt + CW'(1);
            end
            if (frame_edge_c) begin
                snap <= q2;
            end
            row         <= row_c;
            col         <= col_c;
            frame_start <= frame_edge_c;
        end
    end

endmodule
